// File: rtl/vga_tile_display.sv
// vga_tile_display: VGA timing generator that paints a GRID_H x GRID_V grid of solid tiles.
module vga_tile_display #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter int SYNC_POL = 0,
  parameter int CLK_DIV = 2,
  parameter int GRID_H = 4,
  parameter int GRID_V = 4,
  parameter int CBITS = 2,
  parameter int BPC = 4,
  localparam int HB = GRID_H > 1 ? $clog2(GRID_H) : 1,
  localparam int VB = GRID_V > 1 ? $clog2(GRID_V) : 1
) (
  input  logic               CLOCK_50,
  input  logic               RESET,
  input  logic               WR_VALID,
  output logic               WR_READY,
  input  logic [HB-1:0]      WR_H,
  input  logic [VB-1:0]      WR_V,
  input  logic [3*CBITS-1:0] WR_COLOR,
  input  logic               WR_FILL,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic [BPC-1:0]     VGA_R,
  output logic [BPC-1:0]     VGA_G,
  output logic [BPC-1:0]     VGA_B,
  output logic [9:0]         PIX_X,
  output logic [9:0]         PIX_Y,
  output logic               FRAME_START
);
  localparam int CW = 3 * CBITS;
  localparam int REP = BPC / CBITS;
  localparam logic SP = SYNC_POL != 0;
  localparam logic [2:0] CD1 = 3'(CLK_DIV - 1);
  localparam logic [9:0] HA = 10'(H_ACTIVE);
  localparam logic [9:0] HS0 = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS1 = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] HT1 = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] VA = 10'(V_ACTIVE);
  localparam logic [9:0] VS0 = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS1 = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] VT1 = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] TW1 = 10'(H_ACTIVE / GRID_H - 1);
  localparam logic [9:0] TH1 = 10'(V_ACTIVE / GRID_V - 1);

  typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} state_t;

  function automatic state_t decode(input logic [9:0] c, a, f, s);
    return c < a ? ACTIVE : c < f ? FRONT : c < s ? SYNC : BACK;
  endfunction

  logic [2:0] pc;
  logic tick, tick_q, h_wrap, accept, commit;
  logic [9:0] hc, vc, hc_nx, vc_nx, hsub, vsub;
  logic [HB-1:0] tx;
  logic [VB-1:0] ty;
  state_t hs, vs, hs_nx, vs_nx;
  logic pend, pend_fill;
  logic [HB-1:0] pend_h;
  logic [VB-1:0] pend_v;
  logic [CW-1:0] pend_c, pix;
  logic [CW-1:0] tiles [GRID_V][GRID_H];

  always_comb begin
    tick = pc == CD1;
    h_wrap = hc == HT1;
    hc_nx = tick ? (h_wrap ? '0 : hc + 10'd1) : hc;
    vc_nx = tick && h_wrap ? (vc == VT1 ? '0 : vc + 10'd1) : vc;
    hs_nx = decode(hc_nx, HA, HS0, HS1);
    vs_nx = decode(vc_nx, VA, VS0, VS1);
    accept = WR_VALID && WR_READY;
    commit = pend && tick && vc >= VA;
    pix = tiles[ty][tx];
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      hs <= ACTIVE;
      vs <= ACTIVE;
    end else begin
      hs <= hs_nx;
      vs <= vs_nx;
    end
  end

  // Tile coordinates track hc/vc with sub-tile counters instead of dividers
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      pc <= '0;
      tick_q <= 1'b0;
      hc <= '0;
      vc <= '0;
      hsub <= '0;
      vsub <= '0;
      tx <= '0;
      ty <= '0;
    end else begin
      pc <= tick ? '0 : pc + 3'd1;
      tick_q <= tick;
      hc <= hc_nx;
      vc <= vc_nx;
      if (tick) begin
        hsub <= h_wrap || hsub == TW1 ? '0 : hsub + 10'd1;
        tx <= h_wrap ? '0 : hsub == TW1 ? tx + 1'b1 : tx;
        if (h_wrap) begin
          vsub <= vc == VT1 || vsub == TH1 ? '0 : vsub + 10'd1;
          ty <= vc == VT1 ? '0 : vsub == TH1 ? ty + 1'b1 : ty;
        end
      end
    end
  end

  // All pixel outputs sample the same hc/vc one cycle after the tick, so sync and colour stay aligned
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      VGA_HS <= ~SP;
      VGA_VS <= ~SP;
      VGA_R <= '0;
      VGA_G <= '0;
      VGA_B <= '0;
      PIX_X <= '0;
      PIX_Y <= '0;
      FRAME_START <= 1'b0;
    end else begin
      FRAME_START <= tick_q && hc == '0 && vc == '0;
      if (tick_q) begin
        VGA_HS <= hs == SYNC ? SP : ~SP;
        VGA_VS <= vs == SYNC ? SP : ~SP;
        PIX_X <= hc;
        PIX_Y <= vc;
        VGA_R <= hs == ACTIVE && vs == ACTIVE ? {REP{pix[CW-1 -: CBITS]}} : '0;
        VGA_G <= hs == ACTIVE && vs == ACTIVE ? {REP{pix[2*CBITS-1 -: CBITS]}} : '0;
        VGA_B <= hs == ACTIVE && vs == ACTIVE ? {REP{pix[CBITS-1:0]}} : '0;
      end
    end
  end

  // Writes wait in a one-entry buffer and land only in vertical blanking
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      pend <= 1'b0;
      WR_READY <= 1'b0;
      for (int i = 0; i < GRID_V; i++)
        for (int j = 0; j < GRID_H; j++)
          tiles[i][j] <= '0;
    end else begin
      WR_READY <= !(accept || (pend && !commit));
      if (accept) begin
        pend <= 1'b1;
        pend_h <= WR_H;
        pend_v <= WR_V;
        pend_c <= WR_COLOR;
        pend_fill <= WR_FILL;
      end else if (commit) begin
        pend <= 1'b0;
        if (pend_fill)
          for (int i = 0; i < GRID_V; i++)
            for (int j = 0; j < GRID_H; j++)
              tiles[i][j] <= pend_c;
        else
          tiles[pend_v][pend_h] <= pend_c;
      end
    end
  end
endmodule

// File: tb/tb_vga_tile_display.sv
// tb_vga_tile_display: random tile writes checked every cycle against a frame-position model.
`define WAIT_FOR(cond, nm) begin int t_; t_ = 0; while (!(cond) && t_ < 3000) begin @(negedge clk); t_++; end if (t_ >= 3000) begin checks++; errors++; $display("FAIL timeout %s", nm); end end

module tb_vga_tile_display;
  localparam int HA = 16, HFP = 2, HSY = 3, HBP = 3;
  localparam int VA = 8, VFP = 1, VSY = 2, VBP = 1;
  localparam int CD = 3, GH = 4, GV = 4;
  localparam int HT = HA + HFP + HSY + HBP, VT = VA + VFP + VSY + VBP, FT = HT * VT;
  localparam int TW = HA / GH, TH = VA / GV;

  typedef struct packed {
    logic hs, vs, fs;
    logic [3:0] r, g, b;
    logic [9:0] x, y;
  } out_t;

  logic clk = 0, rst = 1, wr_valid = 0, wr_fill = 0;
  logic [1:0] wr_h = 0, wr_v = 0;
  logic [5:0] wr_color = 0;
  logic rdy, hs, vs, fs, rdy2, hs2, vs2, fs2;
  logic [3:0] r, g, b, r2, g2, b2;
  logic [9:0] px, py, px2, py2;
  int checks = 0, errors = 0;
  int k = 0;
  bit armed = 0, mpend = 0, mready = 0, pfill;
  logic [1:0] ph, pv;
  logic [5:0] pcol;
  logic [5:0] mt [GV][GH];

  always #5 clk = ~clk;

  vga_tile_display #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .SYNC_POL(0), .CLK_DIV(CD),
    .GRID_H(GH), .GRID_V(GV), .CBITS(2), .BPC(4)) dut (
    .CLOCK_50(clk), .RESET(rst), .WR_VALID(wr_valid), .WR_READY(rdy), .WR_H(wr_h),
    .WR_V(wr_v), .WR_COLOR(wr_color), .WR_FILL(wr_fill), .VGA_HS(hs), .VGA_VS(vs),
    .VGA_R(r), .VGA_G(g), .VGA_B(b), .PIX_X(px), .PIX_Y(py), .FRAME_START(fs));

  vga_tile_display #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .SYNC_POL(1), .CLK_DIV(1),
    .GRID_H(GH), .GRID_V(GV), .CBITS(2), .BPC(4)) dut2 (
    .CLOCK_50(clk), .RESET(rst), .WR_VALID(1'b0), .WR_READY(rdy2), .WR_H(2'd0),
    .WR_V(2'd0), .WR_COLOR(6'd0), .WR_FILL(1'b0), .VGA_HS(hs2), .VGA_VS(vs2),
    .VGA_R(r2), .VGA_G(g2), .VGA_B(b2), .PIX_X(px2), .PIX_Y(py2), .FRAME_START(fs2));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  // Outputs k edges after release show the position reached after floor((k-1)/cd) ticks
  function automatic out_t expf(input int kk, input int cd, input bit sp, input bit use_t);
    out_t o;
    int n, p, x, y;
    logic [5:0] c;
    o = '0;
    o.hs = ~sp;
    o.vs = ~sp;
    if (kk == 0 || (kk - 1) / cd == 0) return o;
    n = (kk - 1) / cd;
    p = n % FT;
    x = p % HT;
    y = p / HT;
    o.x = 10'(x);
    o.y = 10'(y);
    o.fs = ((kk - 1) % cd == 0) && p == 0;
    o.hs = (x >= HA + HFP && x < HA + HFP + HSY) ? sp : ~sp;
    o.vs = (y >= VA + VFP && y < VA + VFP + VSY) ? sp : ~sp;
    c = (use_t && x < HA && y < VA) ? mt[y / TH][x / TW] : 6'd0;
    o.r = {c[5:4], c[5:4]};
    o.g = {c[3:2], c[3:2]};
    o.b = {c[1:0], c[1:0]};
    return o;
  endfunction

  always @(posedge clk) begin
    armed = 1;
    if (rst) begin
      k = 0;
      mpend = 0;
      mready = 0;
      foreach (mt[i, j]) mt[i][j] = '0;
    end else begin
      k++;
      if (k % CD == 0 && mpend && ((k / CD - 1) % FT) / HT >= VA) begin
        if (pfill) foreach (mt[i, j]) mt[i][j] = pcol;
        else mt[pv][ph] = pcol;
        mpend = 0;
      end
      if (wr_valid && mready) begin
        mpend = 1;
        ph = wr_h;
        pv = wr_v;
        pcol = wr_color;
        pfill = wr_fill;
      end
      mready = !mpend;
    end
  end

  always @(negedge clk) if (armed) begin
    chk("dut_out", 64'({hs, vs, fs, r, g, b, px, py}), 64'(expf(k, CD, 0, 1)));
    chk("dut_ready", 64'(rdy), 64'(mready));
    chk("dut2_out", 64'({hs2, vs2, fs2, r2, g2, b2, px2, py2}), 64'(expf(k, 1, 1, 0)));
    chk("dut2_ready", 64'(rdy2), 64'(k >= 1));
  end

  initial begin
    int c, lo;
    repeat (3) @(negedge clk);
    chk("reset_rgb", 64'({r, g, b}), 64'(0));
    chk("reset_ready", 64'(rdy), 64'(0));
    chk("reset_hs", 64'(hs), 64'(1));
    chk("reset_hs2", 64'(hs2), 64'(0));
    rst = 0;
    c = 0;
    while (!fs && c < 3000) begin
      @(negedge clk);
      c++;
      if (c == 1) chk("ready_after_reset", 64'(rdy), 64'(1));
    end
    chk("first_frame_start", 64'(c), 64'(FT * CD + 1));
    lo = 0;
    repeat (HT * CD) begin @(negedge clk); lo += int'(!hs); end
    chk("hs_low_per_line", 64'(lo), 64'(HSY * CD));
    lo = 0;
    repeat (FT * CD) begin @(negedge clk); lo += int'(!vs); end
    chk("vs_low_per_frame", 64'(lo), 64'(VSY * HT * CD));
    lo = 0;
    repeat (HT) begin @(negedge clk); lo += int'(hs2); end
    chk("hs2_high_per_line", 64'(lo), 64'(HSY));
    `WAIT_FOR(px2 == 2 && py2 < VA, "pix2")
    for (int i = 3; i < 11; i++) begin
      @(negedge clk);
      chk("pix2_step", 64'(px2), 64'(i));
    end
    // Single tile write mid-frame, then a competing request while it is pending
    `WAIT_FOR(px == 0 && py == 1, "row1")
    wr_valid = 1; wr_h = 1; wr_v = 2; wr_color = 6'b110000; wr_fill = 0;
    `WAIT_FOR(mpend, "accept1")
    wr_h = 0; wr_v = 0; wr_color = 6'b000011;
    repeat (20) @(negedge clk);
    chk("ready_low_pending", 64'(rdy), 64'(0));
    wr_valid = 0;
    `WAIT_FOR(px == 5 && py == 4, "old_pix")
    chk("tile_old_frame", 64'({r, g, b}), 64'(0));
    `WAIT_FOR(fs, "fs1")
    `WAIT_FOR(px == 5 && py == 4, "new_pix")
    chk("tile_new_frame", 64'({r, g, b}), 64'(12'hF00));
    `WAIT_FOR(px == 2 && py == 4, "left_pix")
    chk("tile_left_black", 64'({r, g, b}), 64'(0));
    `WAIT_FOR(px == 5 && py == 6, "below_pix")
    chk("tile_below_black", 64'({r, g, b}), 64'(0));
    `WAIT_FOR(mready, "ready_fill")
    wr_valid = 1; wr_color = 6'b010101; wr_fill = 1;
    `WAIT_FOR(mpend, "accept_fill")
    wr_valid = 0; wr_fill = 0;
    `WAIT_FOR(fs, "fs2")
    chk("fill_origin", 64'({r, g, b}), 64'(12'h555));
    `WAIT_FOR(px == 15 && py == 7, "fill_corner")
    chk("fill_corner", 64'({r, g, b}), 64'(12'h555));
    `WAIT_FOR(px == 17 && py == 7, "fill_porch")
    chk("fill_porch_black", 64'({r, g, b}), 64'(0));
    repeat (4000) begin
      @(negedge clk);
      wr_valid = ($urandom % 3) == 0;
      wr_h = 2'($urandom);
      wr_v = 2'($urandom);
      wr_color = 6'($urandom);
      wr_fill = ($urandom % 6) == 0;
    end
    wr_valid = 0; wr_fill = 0;
    // Reset mid-line with a write still pending
    `WAIT_FOR(mready, "ready_mid")
    `WAIT_FOR(py == 1, "row1_mid")
    wr_valid = 1; wr_h = 3; wr_v = 3; wr_color = 6'b111111;
    `WAIT_FOR(mpend, "accept_mid")
    wr_valid = 0;
    `WAIT_FOR(px == 7 && py == 3, "mid_pos")
    chk("pending_before_reset", 64'(rdy), 64'(0));
    rst = 1;
    repeat (2) @(negedge clk);
    chk("midreset_rgb", 64'({r, g, b}), 64'(0));
    chk("midreset_hs_vs", 64'({hs, vs, fs}), 64'(3'b110));
    chk("midreset_ready", 64'(rdy), 64'(0));
    rst = 0;
    c = 0;
    while (!fs && c < 3000) begin @(negedge clk); c++; end
    chk("frame_start_after_reset", 64'(c), 64'(FT * CD + 1));
    repeat (FT * CD) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
